// File: rtl/z_core_mult_pkg.sv
// Z-Core multiplier shared package.
// Holds width constants and the reduction-tree row-count helpers.
package z_core_mult_pkg;

    localparam int XLEN    = 32;
    localparam int PROD_W  = 64;
    localparam int EXT_W   = 33;

    // One row per multiplier bit plus one row for the +1 of the
    // negated sign row.
    localparam int PP_ROWS = EXT_W + 1;

    // Rows remaining after lvl levels of 3:2 compression.
    function automatic int rows_at(int lvl);
        int n;
        n = PP_ROWS;
        for (int i = 0; i < lvl; i++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    // Number of levels needed to reach two rows.
    function automatic int tree_levels();
        int n;
        int l;
        n = PP_ROWS;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = tree_levels();

endpackage

// File: rtl/z_core_csa.sv
// Parameterised-width 3:2 carry-save compressor.
// Ports: a/b/c in; sum = a^b^c; carry = majority(a,b,c) << 1.
module z_core_csa #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    // Top carry bit falls off: arithmetic is modulo 2^W.
    assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/z_core_mult_unit.sv
// Z-Core RV32M 32x32->64 tree multiplier with per-operand signedness.
// Ports: clk, rstn, op1/op2 (+_signed), in_valid -> result (comb),
//        result_q / out_valid (registered, 1-cycle latency).
module z_core_mult_unit
    import z_core_mult_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic [XLEN-1:0]     op1,
    input  logic [XLEN-1:0]     op2,
    input  logic                op1_signed,
    input  logic                op2_signed,
    input  logic                in_valid,
    output logic [PROD_W-1:0]   result,
    output logic [PROD_W-1:0]   result_q,
    output logic                out_valid
);

    logic [EXT_W-1:0]  a_ext;
    logic [EXT_W-1:0]  b_ext;
    logic [PROD_W-1:0] a_sx;

    // Row storage for every tree level; level 0 holds the partial products.
    logic [PROD_W-1:0] tree [0:LEVELS][0:PP_ROWS-1];

    assign a_ext = {op1_signed & op1[XLEN-1], op1};
    assign b_ext = {op2_signed & op2[XLEN-1], op2};

    // Multiplicand sign-extended to the product width.
    assign a_sx = {{(PROD_W-EXT_W){a_ext[EXT_W-1]}}, a_ext};

    // Rows 0..31 carry positive weight 2^j.
    for (genvar j = 0; j < EXT_W - 1; j++) begin : g_pp
        assign tree[0][j] = b_ext[j] ? (a_sx << j) : '0;
    end

    // Row 32 has weight -2^32: add ~(A<<32) and a +1 correction row.
    assign tree[0][EXT_W-1] = b_ext[EXT_W-1] ? ~(a_sx << (EXT_W-1)) : '0;
    assign tree[0][EXT_W]   = {{(PROD_W-1){1'b0}}, b_ext[EXT_W-1]};

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N  = rows_at(l);
        localparam int NN = rows_at(l + 1);
        localparam int G  = N / 3;

        for (genvar g = 0; g < G; g++) begin : g_csa
            z_core_csa #(
                .W (PROD_W)
            ) u_csa (
                .a     (tree[l][3*g]),
                .b     (tree[l][3*g+1]),
                .c     (tree[l][3*g+2]),
                .sum   (tree[l+1][2*g]),
                .carry (tree[l+1][2*g+1])
            );
        end

        // Leftover rows ride through to the next level untouched.
        for (genvar r = 0; r < N % 3; r++) begin : g_pass
            assign tree[l+1][2*G+r] = tree[l][3*G+r];
        end

        for (genvar z = NN; z < PP_ROWS; z++) begin : g_zero
            assign tree[l+1][z] = '0;
        end
    end

    // Final carry-propagate adder.
    assign result = tree[LEVELS][0] + tree[LEVELS][1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result_q  <= '0;
            out_valid <= 1'b0;
        end else begin
            result_q  <= result;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_z_core_mult_unit.sv
// Self-checking bench for z_core_mult_unit.
// Directed table, register/reset checks, and a randomized scoreboard run.
module tb_z_core_mult_unit;

    logic        clk;
    logic        rstn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        op1_signed;
    logic        op2_signed;
    logic        in_valid;
    logic [63:0] result;
    logic [63:0] result_q;
    logic        out_valid;

    int tests;
    int fails;

    typedef struct {
        logic        vld;
        logic [63:0] prod;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb;
        logic [63:0] p;
    } vec_t;

    z_core_mult_unit dut (
        .clk        (clk),
        .rstn       (rstn),
        .op1        (op1),
        .op2        (op2),
        .op1_signed (op1_signed),
        .op2_signed (op2_signed),
        .in_valid   (in_valid),
        .result     (result),
        .result_q   (result_q),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: widen each operand to 64 bits by its own signedness
    // and take the ordinary product modulo 2^64.
    function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b,
                                          logic sa, logic sb);
        longint x;
        longint y;
        x = sa ? longint'(signed'(a)) : longint'({32'b0, a});
        y = sb ? longint'(signed'(b)) : longint'({32'b0, b});
        return 64'(x * y);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [31:0] a, logic [31:0] b,
                         logic sa, logic sb, logic v);
        exp_t e;
        op1        = a;
        op2        = b;
        op1_signed = sa;
        op2_signed = sb;
        in_valid   = v;
        #1;
        e.vld  = v;
        e.prod = model(a, b, sa, sb);
        sb_q.push_back(e);
    endtask

    // Monitor: each edge retires the oldest issued operation.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("out_valid", {63'b0, out_valid}, {63'b0, e.vld});
            chk("result_q", result_q, e.prod);
        end
    end

    vec_t dir[$];

    initial begin
        tests = 0;
        fails = 0;
        rstn = 1'b0;
        op1 = '0;
        op2 = '0;
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        in_valid = 1'b0;

        dir = '{
            '{32'h0,        32'h0,        0, 0, 64'h0},
            '{32'h7,        32'h6,        0, 0, 64'd42},
            '{32'hFF,       32'hFF,       0, 0, 64'hFE01},
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE00000001},
            '{32'hFFFFFFFF, 32'h2,        0, 0, 64'h00000001FFFFFFFE},
            '{32'h80000000, 32'h2,        0, 0, 64'h100000000},
            '{32'hFFFFFFFF, 32'h1,        1, 1, 64'hFFFFFFFFFFFFFFFF},
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 64'h1},
            '{32'hFFFFFFF6, 32'h5,        1, 1, 64'hFFFFFFFFFFFFFFCE},
            '{32'hA,        32'hFFFFFFFB, 1, 1, 64'hFFFFFFFFFFFFFFCE},
            '{32'hFFFFFFF6, 32'hFFFFFFFB, 1, 1, 64'd50},
            '{32'h7FFFFFFF, 32'h2,        1, 1, 64'hFFFFFFFE},
            '{32'h80000000, 32'hFFFFFFFF, 1, 1, 64'h80000000},
            '{32'hFFFFFFF6, 32'h2,        1, 0, 64'hFFFFFFFFFFFFFFEC},
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 64'hFFFFFFFF00000001},
            '{32'h1,        32'hFFFFFFFF, 1, 0, 64'hFFFFFFFF},
            '{32'h2,        32'hFFFFFFFF, 0, 1, 64'hFFFFFFFFFFFFFFFE}
        };

        #3;
        chk("rst_result_q", result_q, 64'h0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'h0);

        // Combinational checks while held in reset.
        foreach (dir[i]) begin
            op1        = dir[i].a;
            op2        = dir[i].b;
            op1_signed = dir[i].sa;
            op2_signed = dir[i].sb;
            #1;
            chk($sformatf("dir%0d", i), result, dir[i].p);
        end

        @(negedge clk);
        rstn = 1'b1;

        // Register stage: valid 7x6, then drop valid.
        @(negedge clk);
        drive(32'd7, 32'd6, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'd7, 32'd6, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        chk("pre_rst_valid", {63'b0, out_valid}, 64'h1);
        rstn = 1'b0;
        #1;
        chk("async_rst_q", result_q, 64'h0);
        chk("async_rst_v", {63'b0, out_valid}, 64'h0);
        chk("rst_comb", result, 64'd42);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b1;

        // Randomized stream through the scoreboard.
        for (int n = 0; n < 10000; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        sa;
            logic        sb;
            logic        v;
            @(negedge clk);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h80000000;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h0;
                default: ;
            endcase
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            v  = 1'($urandom_range(0, 1));
            drive(a, b, sa, sb, v);
            chk("rand_comb", result, model(a, b, sa, sb));
        end

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            @(negedge clk);
        end
        if (sb_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/z_core_mult_unit.md
# z_core_mult_unit

Combinational 32×32→64-bit tree multiplier for the Z-Core RV32M execute stage. Each operand carries its own signedness flag, so one datapath serves MUL, MULH, MULHSU and MULHU; the consumer selects the low or high word. A registered copy of the product, with a valid flag, is provided for pipelined integration on the core clock.

## Interface
- Parameters: none. Widths are fixed by package constants (see Structure).
- `clk` input, 1: core clock; drives only the output register stage.
- `rstn` input, 1: asynchronous, active-low reset.
- `op1` input, 32: multiplicand.
- `op2` input, 32: multiplier.
- `op1_signed` input, 1: 1 means `op1` is two's complement; 0 means unsigned.
- `op2_signed` input, 1: 1 means `op2` is two's complement; 0 means unsigned.
- `in_valid` input, 1: qualifies the operands for the register stage.
- `result` output, 64: combinational full product.
- `result_q` output, 64: `result` registered on `clk`.
- `out_valid` output, 1: `in_valid` registered on `clk`; marks `result_q` as valid.

## Operation
- Extend each operand to 33 bits. The extension bit is `opX_signed & opX[31]`.
- Form the 33×33 two's-complement product.
- `result` is bits [63:0] of that product. This is exact in every mode, because the magnitude fits in 64 bits.
- Partial products are radix-2 AND terms on the 33-bit operands:
  - Sign handling uses Baugh-Wooley. The top row and column are inverted, and correction constants are added.
  - Equivalent sign-extended rows are also acceptable.
- Reduction uses a Wallace or Dadda tree of 3:2 carry-save compressors, reduced to two rows.
- A single 64-bit carry-propagate adder produces the final sum.
- All arithmetic is modulo 2^64. There is no overflow flag. For example, 0x80000000 × 0xFFFFFFFF with both operands signed gives 0x0000000080000000.
- `op1_signed=0` with `op2_signed=1` is supported symmetrically, although RV32M does not use it.
- No X propagation: known inputs always produce a fully known `result`.

## Timing
- `result` is purely combinational.
  - It is valid within the same evaluation after any input change.
  - It is independent of `clk` and `rstn`; reset does not force it.
- Register stage, on each rising `clk`:
  - `result_q <= result`.
  - `out_valid <= in_valid`.
  - Latency is 1 cycle, one new operation per cycle, with no stall or backpressure.
- Reset values: `result_q = 0` and `out_valid = 0`. Both clear immediately when `rstn` falls.
- Reset asserted mid-operation discards the in-flight result. The first valid output after release comes one cycle after the first sampled `in_valid=1`.
- Operands may change on every cycle. `result_q` tracks the operands sampled at each edge, whether or not `in_valid` is set.

## Structure
- Shared package `z_core_mult_pkg` holds:
  - `XLEN = 32`.
  - `PROD_W = 64`.
  - The extended operand width `EXT_W = 33`.
- One sub-module, `z_core_csa`, is the natural split. It is a parameterised-width 3:2 compressor (sum = a^b^c, carry = majority, shifted left by 1) and is instantiated per tree level.
- The partial-product generator, reduction tree, final adder and register stage stay in the top module.

## Test plan
- Unsigned, both flags 0, checking `result` after settle:
  - 0×0 → 0.
  - 7×6 → 42.
  - 0xFF×0xFF → 0xFE01.
  - 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE00000001.
  - 0xFFFFFFFF×2 → 0x00000001FFFFFFFE.
  - 0x80000000×2 → 0x100000000.
- Signed×signed:
  - -1×1 → 0xFFFFFFFFFFFFFFFF.
  - -1×-1 → 1.
  - -10×5 and 10×-5 → 0xFFFFFFFFFFFFFFCE.
  - -10×-5 → 50.
  - 0x7FFFFFFF×2 → 0xFFFFFFFE.
  - 0x80000000×-1 → 0x80000000.
- Signed×unsigned (op1_signed=1, op2_signed=0):
  - 0xFFFFFFF6×2 → 0xFFFFFFFFFFFFFFEC.
  - 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF00000001.
  - 1×0xFFFFFFFF → 0xFFFFFFFF.
- Unsigned×signed (op1_signed=0, op2_signed=1):
  - 2×0xFFFFFFFF → 0xFFFFFFFFFFFFFFFE.
- Register stage:
  - Drive `in_valid=1` with 7×6 on one edge: `result_q=42` and `out_valid=1` after that edge.
  - Drop `in_valid` on the next edge: `out_valid=0`.
- Reset: assert `rstn=0` between edges while `out_valid=1`. `result_q` and `out_valid` must clear immediately, with no clock edge, while `result` still shows the combinational product.
- Random: 10k random operand and flag combinations compared against a 64-bit behavioural signed/unsigned product.
